// File: rtl/display_sequencer.sv
// Game-level display controller: idle/attract, in-game countdown with BCD score,
// and blinking game-over score, driving the board's digit and LED holders.
module display_sequencer #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int BLINK_DIV    = 25_000_000,
  parameter int GAME_SECONDS = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       userquit,
  input  logic       match,
  input  logic       all_matched,
  input  logic [3:0] mode_sel,
  input  logic [9:0] tiles_left,
  output logic       ingameOn,
  output logic       gameOver,
  output logic [3:0] hex0hldr,
  output logic [3:0] hex2hldr,
  output logic [3:0] hex3hldr,
  output logic [3:0] hex4hldr,
  output logic [3:0] hex5hldr,
  output logic [9:0] ledrhldr
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [7:0]    GAME_BCD   = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};
  localparam logic [3:0]    BLANK      = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  // Two-digit BCD decrement; callers never pass 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Two-digit BCD increment that holds at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  state_t          r_state;
  logic [7:0]      r_timer;
  logic [7:0]      r_score;
  logic [TW-1:0]   r_presc;
  logic [BW-1:0]   r_bcnt;
  logic            r_bvis;

  state_t          w_state;
  logic [7:0]      w_timer;
  logic [7:0]      w_score;
  logic [TW-1:0]   w_presc;
  logic [BW-1:0]   w_bcnt;
  logic            w_bvis;
  logic            w_tick;
  logic            w_load;

  always_comb begin
    w_state = r_state;
    w_timer = r_timer;
    w_score = r_score;
    w_presc = r_presc;
    w_bcnt  = r_bcnt;
    w_bvis  = r_bvis;
    w_tick  = (r_state == S_PLAY) && (r_presc == TICK_LAST);
    w_load  = !userquit && start && (r_state != S_PLAY);
    if (userquit) begin
      w_state = S_IDLE;
    end else begin
      case (r_state)
        S_PLAY: begin
          w_presc = w_tick ? '0 : r_presc + 1'b1;
          if (w_tick) w_timer = bcd_dec(r_timer);
          if (match)  w_score = bcd_inc_sat(r_score);
          if ((w_tick && r_timer == 8'h01) || all_matched) begin
            w_state = S_OVER;
            w_bcnt  = '0;
            w_bvis  = 1'b1;
          end
        end
        S_OVER: begin
          if (r_bcnt == BLINK_LAST) begin
            w_bcnt = '0;
            w_bvis = ~r_bvis;
          end else begin
            w_bcnt = r_bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
    // A new game from IDLE or OVER reloads the timer and clears the score.
    if (w_load) begin
      w_state = S_PLAY;
      w_timer = GAME_BCD;
      w_score = 8'h00;
      w_presc = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_timer  <= 8'h00;
      r_score  <= 8'h00;
      r_presc  <= '0;
      r_bcnt   <= '0;
      r_bvis   <= 1'b1;
      ingameOn <= 1'b0;
      gameOver <= 1'b0;
      hex0hldr <= 4'h0;
      hex2hldr <= BLANK;
      hex3hldr <= BLANK;
      hex4hldr <= BLANK;
      hex5hldr <= BLANK;
      ledrhldr <= '0;
    end else begin
      r_state  <= w_state;
      r_timer  <= w_timer;
      r_score  <= w_score;
      r_presc  <= w_presc;
      r_bcnt   <= w_bcnt;
      r_bvis   <= w_bvis;
      hex0hldr <= mode_sel;
      ingameOn <= (w_state == S_PLAY);
      gameOver <= (w_state == S_OVER);
      case (w_state)
        S_PLAY: begin
          hex5hldr <= w_timer[7:4];
          hex4hldr <= w_timer[3:0];
          hex3hldr <= w_score[7:4];
          hex2hldr <= w_score[3:0];
          ledrhldr <= tiles_left;
        end
        S_OVER: begin
          hex5hldr <= BLANK;
          hex4hldr <= BLANK;
          hex3hldr <= w_bvis ? w_score[7:4] : BLANK;
          hex2hldr <= w_bvis ? w_score[3:0] : BLANK;
          ledrhldr <= w_bvis ? '1 : '0;
        end
        default: begin
          hex5hldr <= BLANK;
          hex4hldr <= BLANK;
          hex3hldr <= BLANK;
          hex2hldr <= BLANK;
          ledrhldr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Bench for display_sequencer: three instances (3 s, 99 s, 10 s games) share the
// stimulus and are compared every cycle against an integer-level game model.
module tb_display_sequencer;

  localparam int TD   = 4;
  localparam int BD   = 2;
  localparam int NDUT = 3;

  function automatic int gs_of(input int i);
    case (i)
      0:       return 3;
      1:       return 99;
      default: return 10;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, userquit = 1'b0, match = 1'b0, all_matched = 1'b0;
  logic [3:0] mode_sel = 4'h0;
  logic [9:0] tiles_left = 10'h0;

  logic       ingame [NDUT];
  logic       gover  [NDUT];
  logic [3:0] h0 [NDUT];
  logic [3:0] h2 [NDUT];
  logic [3:0] h3 [NDUT];
  logic [3:0] h4 [NDUT];
  logic [3:0] h5 [NDUT];
  logic [9:0] ledr [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    display_sequencer #(
      .TICK_DIV(TD), .BLINK_DIV(BD), .GAME_SECONDS(gs_of(g))
    ) u_dut (
      .CLOCK_50(clk), .reset(rst), .start(start), .userquit(userquit),
      .match(match), .all_matched(all_matched), .mode_sel(mode_sel),
      .tiles_left(tiles_left), .ingameOn(ingame[g]), .gameOver(gover[g]),
      .hex0hldr(h0[g]), .hex2hldr(h2[g]), .hex3hldr(h3[g]), .hex4hldr(h4[g]),
      .hex5hldr(h5[g]), .ledrhldr(ledr[g])
    );
  end

  // Game model: 0 idle, 1 play, 2 over; timer/score as plain integers.
  int m_st [NDUT];
  int m_tmr [NDUT];
  int m_sc [NDUT];
  int m_presc [NDUT];
  int m_bcnt [NDUT];
  bit m_vis [NDUT];
  int m_h0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_st[i] = 0; m_tmr[i] = 0; m_sc[i] = 0;
      m_presc[i] = 0; m_bcnt[i] = 0; m_vis[i] = 1'b1;
    end
    m_h0 = 0;
  endtask

  task automatic model_step();
    bit tick;
    for (int i = 0; i < NDUT; i++) begin
      if (userquit) begin
        m_st[i] = 0;
      end else if (m_st[i] == 1) begin
        tick = (m_presc[i] == TD - 1);
        m_presc[i] = tick ? 0 : m_presc[i] + 1;
        if (tick) m_tmr[i] = m_tmr[i] - 1;
        if (match && m_sc[i] < 99) m_sc[i] = m_sc[i] + 1;
        if ((tick && m_tmr[i] == 0) || all_matched) begin
          m_st[i] = 2; m_bcnt[i] = 0; m_vis[i] = 1'b1;
        end
      end else if (start) begin
        m_st[i] = 1; m_tmr[i] = gs_of(i); m_sc[i] = 0; m_presc[i] = 0;
      end else if (m_st[i] == 2) begin
        if (m_bcnt[i] == BD - 1) begin
          m_bcnt[i] = 0; m_vis[i] = !m_vis[i];
        end else begin
          m_bcnt[i] = m_bcnt[i] + 1;
        end
      end
    end
    m_h0 = int'(mode_sel);
  endtask

  task automatic check_all();
    int e5, e4, e3, e2, el, ei, eg;
    for (int i = 0; i < NDUT; i++) begin
      case (m_st[i])
        1: begin
          e5 = m_tmr[i] / 10; e4 = m_tmr[i] % 10;
          e3 = m_sc[i] / 10;  e2 = m_sc[i] % 10;
          el = int'(tiles_left); ei = 1; eg = 0;
        end
        2: begin
          e5 = 15; e4 = 15;
          e3 = m_vis[i] ? m_sc[i] / 10 : 15;
          e2 = m_vis[i] ? m_sc[i] % 10 : 15;
          el = m_vis[i] ? 'h3FF : 0; ei = 0; eg = 1;
        end
        default: begin
          e5 = 15; e4 = 15; e3 = 15; e2 = 15; el = 0; ei = 0; eg = 0;
        end
      endcase
      chk($sformatf("u%0d.hex0", i), 32'(h0[i]), m_h0);
      chk($sformatf("u%0d.hex5", i), 32'(h5[i]), e5);
      chk($sformatf("u%0d.hex4", i), 32'(h4[i]), e4);
      chk($sformatf("u%0d.hex3", i), 32'(h3[i]), e3);
      chk($sformatf("u%0d.hex2", i), 32'(h2[i]), e2);
      chk($sformatf("u%0d.ledr", i), 32'(ledr[i]), el);
      chk($sformatf("u%0d.ingameOn", i), 32'(ingame[i]), ei);
      chk($sformatf("u%0d.gameOver", i), 32'(gover[i]), eg);
    end
  endtask

  task automatic cyc(input bit s, input bit q, input bit m, input bit am);
    start = s; userquit = q; match = m; all_matched = am;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear without a clock edge.
  task automatic async_reset();
    start = 1'b0; userquit = 1'b0; match = 1'b0; all_matched = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    #1;
    async_reset();

    // Countdown from 3 s; the 10 s instance shows the BCD borrow.
    mode_sel = 4'h5;
    tiles_left = 10'h2A5;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("plan.start_hex5", 32'(h5[0]), 32'h0);
    chk("plan.start_hex4", 32'(h4[0]), 32'h3);
    chk("plan.start_ingame", 32'(ingame[0]), 32'h1);
    idle(4);
    chk("plan.tick_hex4", 32'(h4[0]), 32'h2);
    chk("plan.borrow_hex5", 32'(h5[2]), 32'h0);
    chk("plan.borrow_hex4", 32'(h4[2]), 32'h9);
    idle(8);
    chk("plan.end_gameover", 32'(gover[0]), 32'h1);
    chk("plan.end_hex5", 32'(h5[0]), 32'hF);

    // Reset in the middle of a running game, then hex0 follows mode_sel.
    idle(1);
    async_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("plan.hex0_track", 32'(h0[0]), 32'h5);

    // Eleven matches, then saturation on the 99 s instance.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (11) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("plan.score_hex3", 32'(h3[0]), 32'h1);
    chk("plan.score_hex2", 32'(h2[0]), 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (120) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("plan.sat_hex3", 32'(h3[1]), 32'h9);
    chk("plan.sat_hex2", 32'(h2[1]), 32'h9);

    // Finish with score 07 and watch the blink.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    chk("plan.over_hex2", 32'(h2[0]), 32'h7);
    chk("plan.over_ledr", 32'(ledr[0]), 32'h3FF);
    idle(2);
    chk("plan.blank_hex2", 32'(h2[0]), 32'hF);
    chk("plan.blank_ledr", 32'(ledr[0]), 32'h0);
    idle(2);
    chk("plan.reshow_hex3", 32'(h3[0]), 32'h0);
    chk("plan.reshow_hex2", 32'(h2[0]), 32'h7);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("plan.restart_hex2", 32'(h2[0]), 32'h0);

    // Priority cases.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("plan.quit_ingame", 32'(ingame[0]), 32'h0);
    chk("plan.quit_hex2", 32'(h2[0]), 32'hF);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(11);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("plan.lastmatch_over", 32'(gover[0]), 32'h1);
    chk("plan.lastmatch_hex2", 32'(h2[0]), 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("plan.allmatched_over", 32'(gover[0]), 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("plan.start_allm_play", 32'(ingame[0]), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("plan.match_allm_over", 32'(gover[0]), 32'h1);
    chk("plan.match_allm_hex2", 32'(h2[0]), 32'h1);

    // Randomized play against the model.
    for (int k = 0; k < 3000; k++) begin
      mode_sel = 4'($urandom_range(0, 15));
      tiles_left = 10'($urandom);
      if (k == 1500) async_reset();
      cyc($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Game-level controller that drives the holder inputs of the board display block: hex0hldr, hex2hldr..hex5hldr and ledrhldr.
- Sequences three display phases: idle/attract, in-game (countdown timer plus BCD score), and game-over (blinking final score).
- Owns the one-second game timer, the score counter, and the ingameOn/gameOver flags used by the rest of the tile-matching design.
- A holder value of 4'hF means a blank digit on the board.

Parameters:
- TICK_DIV, 50_000_000, clock cycles per one-second timer tick (must be ≥2).
- BLINK_DIV, 25_000_000, clock cycles per game-over blink half-period (must be ≥1).
- GAME_SECONDS, 60, game length in seconds, legal range 1..99, loaded as two BCD digits.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  reset. One clock; reset is asynchronous and active-high.
- start  in  1  one-cycle pulse that begins a game.
- userquit  in  1  level or pulse that abandons the game and returns to idle.
- match  in  1  one-cycle pulse when a tile pair is matched; adds one to the score.
- all_matched  in  1  level, board fully cleared.
- mode_sel  in  4  selected difficulty, shown on HEX0 in every state.
- tiles_left  in  10  unmatched-tile mask, shown on LEDR during play.
- ingameOn  out  1  high in PLAY.
- gameOver  out  1  high in OVER.
- hex0hldr, hex2hldr, hex3hldr, hex4hldr, hex5hldr  out  4 each  display digit codes.
- ledrhldr  out  10  LED pattern.

Behaviour:
- Reset values: state IDLE; ingameOn=0, gameOver=0; hex2..hex5=4'hF; hex0hldr=4'h0; ledrhldr=0; score=00; timer=00; prescaler=0; blink phase=visible.
- All outputs are registered. Outputs reflect an input event on the clock edge after it is sampled (latency 1).
- hex0hldr = mode_sel, registered, in every state.

IDLE:
- hex2..hex5 blank, ledrhldr=0.
- start → PLAY. On that edge: timer loads GAME_SECONDS as BCD (tens→hex5, ones→hex4), score clears to 00 (tens→hex3, ones→hex2), prescaler clears.

PLAY:
- ingameOn=1. ledrhldr=tiles_left, registered.
- Prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 a tick occurs and the prescaler wraps to 0.
- On a tick the timer decrements in BCD: ones 0 → 9 with tens borrow.
- match increments the score in BCD: ones 9 → 0 with tens carry. The score saturates at 99.
- PLAY → OVER when either of these happens:
  - a tick takes the timer to 00 (same edge);
  - all_matched=1 (registered).
- start in PLAY is ignored.

OVER:
- gameOver=1, ingameOn=0. hex5/hex4 blank.
- Score is frozen. hex3/hex2 show the score on the visible phase and 4'hF on the blank phase.
- ledrhldr is all ones on the visible phase and 0 on the blank phase.
- Blink counter counts 0..BLINK_DIV-1 and toggles the phase at wrap. The counter restarts and the phase is set to visible on entry to OVER.
- start → PLAY with the same load as from IDLE.

Priority and boundary rules:
- userquit in any state → IDLE on the next edge, with IDLE outputs. It overrides start, match, tick and all_matched on the same cycle.
- match on the same cycle as the final tick: the score is incremented, then OVER is entered on that edge.
- match and all_matched together: the score is incremented and OVER is entered.
- all_matched=1 at the cycle start is sampled: the game enters PLAY, then OVER on the next edge.
- match outside PLAY is ignored.
- Reset asserted mid-game: immediate async return to the reset values.

Test Plan (TICK_DIV=4, BLINK_DIV=2, GAME_SECONDS=3 unless stated):
- Reset then idle: assert reset mid-PLAY → outputs go to the reset values immediately; hex2..5=F, LEDR=0; hex0 tracks mode_sel=4'h5 one cycle later.
- Start and countdown: start pulse → hex5/hex4=0/3, hex3/hex2=0/0, ingameOn=1. After 4 cycles hex4=2; after 12 cycles timer 00, gameOver=1, hex5/hex4=F.
- Scoring: 11 match pulses in PLAY → hex3/hex2=1/1. With GAME_SECONDS=99, 120 pulses → score saturates at 9/9.
- BCD borrow: GAME_SECONDS=10, one tick → hex5/hex4=0/9.
- Game-over blink: finish with score 07 → hex3/hex2 alternate 0/7 and F/F every 2 cycles; LEDR alternates 3FF and 000. A start pulse → PLAY with score 00.
- Priority: userquit, start and match asserted together in PLAY → IDLE next edge, score unchanged. match on the final tick edge → OVER showing the incremented score. all_matched in PLAY → OVER next edge.
